// File: rtl/ball_engine.sv
`timescale 1ns/1ps
// Purpose: game-physics stage feeding the VGA renderer; owns the ball position and direction, serves, bounces and scores.
// Latency: all outputs registered; position/state change on the clk edge that samples frame_tick (serve accepted on its own edge).
// Backpressure: none; frame_tick and serve are single-clk pulses consumed when seen, score pulses last exactly one clk.
//
// Ports:
//   clk, reset (async, active-low)
//   frame_tick, serve                     : one-clk control pulses
//   paddle_left_pos, paddle_right_pos     : paddle top y, sampled on frame_tick
//   ball_pos_x, ball_pos_y                : ball top-left corner, straight to the renderer
//   ball_active, score_left, score_right  : PLAY indicator and one-clk score pulses
//   state                                 : IDLE=0, SERVE_WAIT=1, PLAY=2, SCORED=3
module ball_engine #(
    parameter int unsigned CANVAS_TOP    = 50,
    parameter int unsigned CANVAS_BOTTOM = 450,
    parameter int unsigned CANVAS_LEFT   = 50,
    parameter int unsigned CANVAS_RIGHT  = 600,
    parameter int unsigned BALL_SIZE     = 10,
    parameter int unsigned PADDLE_OFFSET = 20,
    parameter int unsigned PADDLE_WIDTH  = 10,
    parameter int unsigned PADDLE_HEIGHT = 50,
    parameter int unsigned BALL_SPEED    = 2,
    parameter int unsigned SERVE_DELAY   = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic [9:0] paddle_left_pos,
    input  logic [9:0] paddle_right_pos,
    output logic [9:0] ball_pos_x,
    output logic [9:0] ball_pos_y,
    output logic       ball_active,
    output logic       score_left,
    output logic       score_right,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_WAIT = 2'd1,
        PLAY       = 2'd2,
        SCORED     = 2'd3
    } state_t;

    // Geometry is evaluated in 11 bits so x-SPEED and x+SIZE+SPEED never wrap.
    localparam logic [10:0] TOP_W    = 11'(CANVAS_TOP);
    localparam logic [10:0] BOTTOM_W = 11'(CANVAS_BOTTOM);
    localparam logic [10:0] LEFT_W   = 11'(CANVAS_LEFT);
    localparam logic [10:0] RIGHT_W  = 11'(CANVAS_RIGHT);
    localparam logic [10:0] SIZE_W   = 11'(BALL_SIZE);
    localparam logic [10:0] SPEED_W  = 11'(BALL_SPEED);
    localparam logic [10:0] PH_W     = 11'(PADDLE_HEIGHT);
    localparam logic [10:0] LFACE    = 11'(CANVAS_LEFT + PADDLE_OFFSET + PADDLE_WIDTH);
    localparam logic [10:0] RFACE    = 11'(CANVAS_RIGHT - PADDLE_OFFSET - PADDLE_WIDTH);
    localparam logic [9:0]  CX       = 10'((CANVAS_LEFT + CANVAS_RIGHT) / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  CY       = 10'((CANVAS_TOP + CANVAS_BOTTOM) / 2 - BALL_SIZE / 2);

    localparam int CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_DELAY - 1);

    // Registered state
    state_t        state_q, state_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          dir_x_q, dir_x_d;      // 1 = right
    logic          dir_y_q, dir_y_d;      // 1 = down
    logic          serve_dir_q, serve_dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          score_l_q, score_l_d;
    logic          score_r_q, score_r_d;

    // Widened operands
    logic [10:0] px, py, pl, pr;
    assign px = {1'b0, x_q};
    assign py = {1'b0, y_q};
    assign pl = {1'b0, paddle_left_pos};
    assign pr = {1'b0, paddle_right_pos};

    // Candidate next-frame motion, only committed in PLAY on frame_tick
    logic       ov_l, ov_r;
    logic [9:0] vy;
    logic       vdir;
    logic [9:0] hx;
    logic       hdir;
    logic       miss_l, miss_r;

    always_comb begin
        // Paddle overlap uses the pre-move y, so horizontal sees the old row.
        ov_l = (py + SIZE_W > pl) && (py < pl + PH_W);
        ov_r = (py + SIZE_W > pr) && (py < pr + PH_W);

        vy   = y_q;
        vdir = dir_y_q;
        if (dir_y_q) begin
            if (py + SIZE_W + SPEED_W > BOTTOM_W) begin
                vy   = 10'(BOTTOM_W - SIZE_W);
                vdir = 1'b0;
            end else begin
                vy = 10'(py + SPEED_W);
            end
        end else begin
            if (py < TOP_W + SPEED_W) begin
                vy   = 10'(TOP_W);
                vdir = 1'b1;
            end else begin
                vy = 10'(py - SPEED_W);
            end
        end

        hx     = x_q;
        hdir   = dir_x_q;
        miss_l = 1'b0;
        miss_r = 1'b0;
        if (!dir_x_q) begin
            // Face-crossing test: a ball already behind the face is never reflected.
            if ((px >= LFACE) && (px - SPEED_W < LFACE) && ov_l) begin
                hx   = 10'(LFACE);
                hdir = 1'b1;
            end else if (px < LEFT_W + SPEED_W) begin
                miss_l = 1'b1;
            end else begin
                hx = 10'(px - SPEED_W);
            end
        end else begin
            if ((px + SIZE_W <= RFACE) && (px + SIZE_W + SPEED_W > RFACE) && ov_r) begin
                hx   = 10'(RFACE - SIZE_W);
                hdir = 1'b0;
            end else if (px + SIZE_W + SPEED_W > RIGHT_W) begin
                miss_r = 1'b1;
            end else begin
                hx = 10'(px + SPEED_W);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        serve_dir_d = serve_dir_q;
        cnt_d       = cnt_q;
        score_l_d   = 1'b0;
        score_r_d   = 1'b0;

        case (state_q)
            IDLE: begin
                x_d = CX;
                y_d = CY;
                // A coincident frame_tick is deliberately not counted.
                if (serve) begin
                    state_d = SERVE_WAIT;
                    cnt_d   = '0;
                    dir_x_d = serve_dir_q;
                    dir_y_d = 1'b1;
                end
            end
            SERVE_WAIT: begin
                if (frame_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = PLAY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    if (miss_l) begin
                        // Ball frozen at its last legal spot; next serve heads to the conceding side.
                        score_r_d   = 1'b1;
                        serve_dir_d = 1'b0;
                        state_d     = SCORED;
                    end else if (miss_r) begin
                        score_l_d   = 1'b1;
                        serve_dir_d = 1'b1;
                        state_d     = SCORED;
                    end else begin
                        x_d     = hx;
                        y_d     = vy;
                        dir_x_d = hdir;
                        dir_y_d = vdir;
                    end
                end
            end
            SCORED: begin
                if (frame_tick) begin
                    x_d     = CX;
                    y_d     = CY;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            x_q         <= CX;
            y_q         <= CY;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            serve_dir_q <= 1'b1;
            cnt_q       <= '0;
            score_l_q   <= 1'b0;
            score_r_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            serve_dir_q <= serve_dir_d;
            cnt_q       <= cnt_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
        end
    end

    assign ball_pos_x  = x_q;
    assign ball_pos_y  = y_q;
    assign ball_active = (state_q == PLAY);
    assign score_left  = score_l_q;
    assign score_right = score_r_q;
    assign state       = state_q;

endmodule

// File: tb/tb_ball_engine.sv
`timescale 1ns/1ps
module tb_ball_engine;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       serve;
    logic [9:0] paddle_left_pos;
    logic [9:0] paddle_right_pos;
    logic [9:0] ball_pos_x;
    logic [9:0] ball_pos_y;
    logic       ball_active;
    logic       score_left;
    logic       score_right;
    logic [1:0] state;

    ball_engine dut (
        .clk              (clk),
        .reset            (reset),
        .frame_tick       (frame_tick),
        .serve            (serve),
        .paddle_left_pos  (paddle_left_pos),
        .paddle_right_pos (paddle_right_pos),
        .ball_pos_x       (ball_pos_x),
        .ball_pos_y       (ball_pos_y),
        .ball_active      (ball_active),
        .score_left       (score_left),
        .score_right      (score_right),
        .state            (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       cp;   // compare position too
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] st;
        logic       sl;
        logic       sr;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  chk_req;

    // Hand-derived checkpoints for the second rally (right paddle 380 then 200, left paddle 180 then 300).
    int r2_k [0:23] = '{  1,  97,  98,  99, 120, 121, 122, 292, 293, 294, 295, 360,
                        361, 362, 363, 489, 490, 491, 602, 603, 604, 843, 844, 858};
    int r2_x [0:23] = '{322, 514, 516, 518, 560, 560, 558, 218, 216, 214, 212,  82,
                         80,  80,  82, 334, 336, 338, 560, 560, 558,  80,  78,  50};
    int r2_y [0:23] = '{247, 439, 440, 438, 396, 394, 392,  52,  50,  50,  52, 182,
                        184, 186, 188, 440, 440, 438, 216, 214, 212, 364, 366, 394};

    task automatic push_exp(input logic cp, input int x, input int y, input int st,
                            input logic sl, input logic sr, input string nm);
        exp_t e;
        e.cp = cp;
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.st = 2'(st);
        e.sl = sl;
        e.sr = sr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic do_tick(input logic cp, input int x, input int y, input int st,
                           input logic sl, input logic sr, input string nm);
        @(posedge clk); #2;
        push_exp(cp, x, y, st, sl, sr, nm);
        frame_tick = 1'b1;
        @(posedge clk); #2;
        frame_tick = 1'b0;
    endtask

    task automatic do_serve(input logic with_tick, input int st, input string nm);
        @(posedge clk); #2;
        push_exp(1'b1, 320, 245, st, 1'b0, 1'b0, nm);
        serve      = 1'b1;
        frame_tick = with_tick;
        @(posedge clk); #2;
        serve      = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic check_now(input int x, input int y, input int st, input string nm);
        @(posedge clk); #2;
        push_exp(1'b1, x, y, st, 1'b0, 1'b0, nm);
        chk_req = 1'b1;
        @(posedge clk); #2;
        chk_req = 1'b0;
    endtask

    // Serve wait: ticks 1..59 hold SERVE_WAIT, tick 60 launches with the ball still at centre.
    task automatic serve_wait(input string nm, input int serve_at);
        for (int t = 1; t <= 60; t++) begin
            if (t == serve_at) do_serve(1'b0, 1, $sformatf("%s_ignored_serve", nm));
            if (t < 60) do_tick(1'b0, 0, 0, 1, 1'b0, 1'b0, $sformatf("%s_wait%0d", nm, t));
            else        do_tick(1'b1, 320, 245, 2, 1'b0, 1'b0, $sformatf("%s_launch", nm));
        end
    endtask

    // Monitor: pops one expectation per clk on which the DUT sampled a stimulus pulse.
    initial begin
        logic trig;
        exp_t e;
        string nm;
        logic ok;
        forever begin
            @(posedge clk);
            trig = frame_tick | serve | chk_req;
            @(negedge clk);
            if (trig) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: no expectation queued, got x=%0d y=%0d st=%0d",
                             ball_pos_x, ball_pos_y, state);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    ok = (state == e.st) && (ball_active == (e.st == 2'd2)) &&
                         (score_left == e.sl) && (score_right == e.sr) &&
                         (!e.cp || ((ball_pos_x == e.x) && (ball_pos_y == e.y)));
                    if (!ok) begin
                        errors++;
                        $display("FAIL %s: got x=%0d y=%0d st=%0d act=%0d sl=%0d sr=%0d, want x=%0d y=%0d st=%0d act=%0d sl=%0d sr=%0d (pos checked=%0d)",
                                 nm, ball_pos_x, ball_pos_y, state, ball_active, score_left, score_right,
                                 e.x, e.y, e.st, (e.st == 2'd2), e.sl, e.sr, e.cp);
                    end
                end
            end else if (score_left || score_right) begin
                checks++;
                errors++;
                $display("FAIL score_pulse_width: got sl=%0d sr=%0d, want 0 0", score_left, score_right);
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, queued=%0d", exp_q.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b0;
        frame_tick       = 1'b0;
        serve            = 1'b0;
        chk_req          = 1'b0;
        paddle_left_pos  = 10'd0;
        paddle_right_pos = 10'd0;
        repeat (3) @(posedge clk);
        check_now(320, 245, 0, "reset_state");
        @(posedge clk); #2;
        reset = 1'b1;

        // Launch, move 40 frames to x=400, then abort with reset.
        do_serve(1'b0, 1, "serve_accept");
        serve_wait("a", 0);
        for (int k = 1; k <= 40; k++)
            do_tick(1'b1, 320 + 2 * k, 245 + 2 * k, 2, 1'b0, 1'b0, $sformatf("a_k%0d", k));
        @(posedge clk); #2;
        reset = 1'b0;
        push_exp(1'b1, 320, 245, 0, 1'b0, 1'b0, "reset_mid_play");
        chk_req = 1'b1;
        @(posedge clk); #2;
        chk_req = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;

        // Serve coincident with frame_tick: that tick must not be counted.
        do_serve(1'b1, 1, "serve_with_tick");
        serve_wait("r1", 10);
        for (int k = 1; k <= 135; k++)
            do_tick(1'b1, 320 + 2 * k, (k <= 97) ? 245 + 2 * k : 440 - 2 * (k - 98), 2,
                    1'b0, 1'b0, $sformatf("r1_k%0d", k));
        do_tick(1'b1, 590, 366, 3, 1'b1, 1'b0, "r1_right_miss");
        do_tick(1'b1, 320, 245, 0, 1'b0, 1'b0, "r1_recentre");

        // Second rally: right paddle bounce, top wall, left paddle bounce, bottom wall, then left miss.
        paddle_left_pos  = 10'd180;
        paddle_right_pos = 10'd380;
        do_serve(1'b0, 1, "r2_serve");
        serve_wait("r2", 0);
        for (int k = 1; k <= 858; k++) begin
            logic cp;
            int   ex, ey;
            cp = 1'b0;
            ex = 0;
            ey = 0;
            if (k == 131) paddle_right_pos = 10'd200;
            if (k == 401) paddle_left_pos  = 10'd300;
            for (int i = 0; i < 24; i++)
                if (r2_k[i] == k) begin
                    cp = 1'b1;
                    ex = r2_x[i];
                    ey = r2_y[i];
                end
            do_tick(cp, ex, ey, 2, 1'b0, 1'b0, $sformatf("r2_k%0d", k));
        end
        do_tick(1'b1, 50, 394, 3, 1'b0, 1'b1, "r2_left_miss");
        do_tick(1'b1, 320, 245, 0, 1'b0, 1'b0, "r2_recentre");

        // Next serve heads left, toward the side that conceded.
        do_serve(1'b0, 1, "r3_serve");
        serve_wait("r3", 0);
        do_tick(1'b1, 318, 247, 2, 1'b0, 1'b0, "r3_k1_left");
        do_tick(1'b1, 316, 249, 2, 1'b0, 1'b0, "r3_k2_left");

        repeat (4) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
